// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch widths, reset PC and instruction field slices.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package cpu_pkg;

   // Instruction-memory address width and instruction word width.
   localparam int PC_W     = 4;
   localparam int INST_W   = 16;
   localparam int RESET_PC = 0;

   // Instruction field positions: [15:12] opcode, then three 4-bit register fields.
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RA_HI  = 11;
   localparam int RA_LO  = 8;
   localparam int RB_HI  = 7;
   localparam int RB_LO  = 4;
   localparam int RC_HI  = 3;
   localparam int RC_LO  = 0;

   typedef logic [PC_W-1:0]   pc_t;
   typedef logic [INST_W-1:0] inst_t;

   // Fetched word as presented to the decoder.
   typedef struct packed {
      inst_t inst;
      pc_t   pc;
   } fetch_word_t;

   function automatic logic [3:0] inst_opcode(input inst_t inst);
      return inst[OPC_HI:OPC_LO];
   endfunction

   function automatic logic [3:0] inst_ra(input inst_t inst);
      return inst[RA_HI:RA_LO];
   endfunction

   function automatic logic [3:0] inst_rb(input inst_t inst);
      return inst[RB_HI:RB_LO];
   endfunction

   function automatic logic [3:0] inst_rc(input inst_t inst);
      return inst[RC_HI:RC_LO];
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// Fetch initiator for the instruction memory: drives pc/mem_stop, tags returned words, presents {inst,pc}.
// Latency: first word 2 advancing edges after reset; branch at edge E gives target word from E+2; 1 word/cycle.
// Backpressure: out_ready=0 or stop=1 freezes all state and holds the memory output via mem_stop; no skid buffer.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stop                global halt, freezes fetch state (branch and reset still act)
//   pc, mem_stop        instruction-memory address and output-hold control
//   instruction         registered memory output, mem[pc] from the previous non-stopped edge
//   branch_valid/target single-cycle redirect from execute
//   out_valid/ready     decoder handshake; out_inst/out_pc carry the fetched word
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int PC_W_P     = PC_W,
   parameter int INST_W_P   = INST_W,
   parameter int RESET_PC_P = RESET_PC
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stop,
   output logic [PC_W_P-1:0]   pc,
   output logic                mem_stop,
   input  logic [INST_W_P-1:0] instruction,
   input  logic                branch_valid,
   input  logic [PC_W_P-1:0]   branch_target,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [INST_W_P-1:0] out_inst,
   output logic [PC_W_P-1:0]   out_pc
);

   localparam logic [PC_W_P-1:0] RST_PC = PC_W_P'(RESET_PC_P);

   logic [PC_W_P-1:0]   pc_q,        pc_d;
   logic                req_valid_q, req_valid_d;
   logic [PC_W_P-1:0]   req_pc_q,    req_pc_d;
   logic                out_valid_q, out_valid_d;
   logic [INST_W_P-1:0] out_inst_q,  out_inst_d;
   logic [PC_W_P-1:0]   out_pc_q,    out_pc_d;
   logic                adv;

   // The whole pipeline moves as one: the output slot is free or being drained, and no halt.
   assign adv      = ~stop & (~out_valid_q | out_ready);
   // When the pipeline cannot move, the memory must keep the word it already fetched,
   // so the tag in req_pc_q stays paired with the word on instruction.
   assign mem_stop = ~adv;

   always_comb begin
      pc_d        = pc_q;
      req_valid_d = req_valid_q;
      req_pc_d    = req_pc_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      if (branch_valid) begin
         // Redirect wins over stall and handshake: drop the word in the memory and the
         // word in the output slot, even if the decoder is taking it this cycle.
         pc_d        = branch_target;
         req_valid_d = 1'b0;
         out_valid_d = 1'b0;
      end else if (adv) begin
         pc_d        = pc_q + 1'b1;     // wraps modulo 2^PC_W
         req_valid_d = 1'b1;
         req_pc_d    = pc_q;
         out_valid_d = req_valid_q;
         out_inst_d  = instruction;
         out_pc_d    = req_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RST_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_pc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         req_valid_q <= req_valid_d;
         req_pc_q    <= req_pc_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign pc        = pc_q;
   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch with a registered, stop-holding instruction memory model (mem[k] = 16'hA000 + k).
// Latency: checks the 2-edge fill, branch refill, and 1 word/cycle streaming.
// Backpressure: exercises out_ready=0 holds, stop holds, branches under stall, and reset mid-stream.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        stop;
   logic [3:0]  pc;
   logic        mem_stop;
   logic [15:0] instruction;
   logic        branch_valid;
   logic [3:0]  branch_target;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_inst;
   logic [3:0]  out_pc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   inst_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .stop          (stop),
      .pc            (pc),
      .mem_stop      (mem_stop),
      .instruction   (instruction),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc)
   );

   // Memory model: active-low reset driven by ~reset, output register holds while mem_stop=1.
   always @(posedge clk) begin
      if (!(~reset))
         instruction <= 16'h0000;
      else if (!mem_stop)
         instruction <= 16'hA000 + {12'h000, pc};
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   // Free-running stream from a fresh reset with out_ready=1: edge k shows word k-2.
   task automatic run_stream(input int n_edges);
      for (int k = 1; k <= n_edges; k++) begin
         edge_sample();
         chk("stream_pc", 32'(pc), 32'(k % 16));
         if (k == 1) begin
            chk("stream_fill_valid", 32'(out_valid), 32'd0);
         end else begin
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_out_pc", 32'(out_pc), 32'((k - 2) % 16));
            chk("stream_out_inst", 32'(out_inst), 32'(16'hA000 + ((k - 2) % 16)));
         end
      end
   endtask

   typedef struct {
      logic       stop;
      logic       rdy;
      logic       br;
      logic [3:0] tgt;
      logic       ms;     // expected mem_stop with these inputs, before the edge
      logic       vld;    // expected out_valid after the edge
      logic [3:0] opc;    // expected out_pc after the edge (checked when vld)
      logic [3:0] pcx;    // expected pc after the edge
   } vec_t;

   vec_t vec[29];

   initial begin
      // Continues from the end of the reset stream: out_pc=3 shown, pc=5.
      // Branch to 12 while word 3 is accepted; word 4 must never appear.
      vec[0]  = '{0,1,1,12, 0, 0, 0,12};
      vec[1]  = '{0,1,0, 0, 0, 0, 0,13};
      vec[2]  = '{0,1,0, 0, 0, 1,12,14};
      vec[3]  = '{0,1,0, 0, 0, 1,13,15};
      // Branch to 0 with the decoder stalled on word 13: flushed at once, word 0 two edges later.
      vec[4]  = '{0,0,1, 0, 1, 0, 0, 0};
      vec[5]  = '{0,0,0, 0, 0, 0, 0, 1};
      vec[6]  = '{0,0,0, 0, 0, 1, 0, 2};
      vec[7]  = '{0,0,0, 0, 1, 1, 0, 2};
      vec[8]  = '{0,1,0, 0, 0, 1, 1, 3};
      vec[9]  = '{0,1,0, 0, 0, 1, 2, 4};
      vec[10] = '{0,1,0, 0, 0, 1, 3, 5};
      vec[11] = '{0,1,0, 0, 0, 1, 4, 6};
      vec[12] = '{0,1,0, 0, 0, 1, 5, 7};
      // Decoder stall for 3 cycles on word 5, then resume with word 6.
      vec[13] = '{0,0,0, 0, 1, 1, 5, 7};
      vec[14] = '{0,0,0, 0, 1, 1, 5, 7};
      vec[15] = '{0,0,0, 0, 1, 1, 5, 7};
      vec[16] = '{0,1,0, 0, 0, 1, 6, 8};
      vec[17] = '{0,1,0, 0, 0, 1, 7, 9};
      vec[18] = '{0,1,0, 0, 0, 1, 8,10};
      vec[19] = '{0,1,0, 0, 0, 1, 9,11};
      // Global stop for 4 cycles on word 9, then resume with word 10.
      vec[20] = '{1,1,0, 0, 1, 1, 9,11};
      vec[21] = '{1,1,0, 0, 1, 1, 9,11};
      vec[22] = '{1,1,0, 0, 1, 1, 9,11};
      vec[23] = '{1,1,0, 0, 1, 1, 9,11};
      vec[24] = '{0,1,0, 0, 0, 1,10,12};
      vec[25] = '{0,1,0, 0, 0, 1,11,13};
      // Branch accepted while stopped.
      vec[26] = '{1,1,1, 7, 1, 0, 0, 7};
      vec[27] = '{0,1,0, 0, 0, 0, 0, 8};
      vec[28] = '{0,1,0, 0, 0, 1, 7, 9};

      reset = 1'b1; stop = 1'b0; out_ready = 1'b1;
      branch_valid = 1'b0; branch_target = 4'd0;
      edge_sample();
      edge_sample();

      // Reset state.
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", 32'(out_pc), 32'd0);
      chk("rst_out_inst", 32'(out_inst), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_mem_stop", 32'(mem_stop), 32'd0);

      reset = 1'b0;
      run_stream(21);

      for (int i = 0; i < 29; i++) begin
         stop          = vec[i].stop;
         out_ready     = vec[i].rdy;
         branch_valid  = vec[i].br;
         branch_target = vec[i].tgt;
         #1;
         chk($sformatf("v%0d_mem_stop", i), 32'(mem_stop), 32'(vec[i].ms));
         edge_sample();
         chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vec[i].pcx));
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].vld));
         if (vec[i].vld) begin
            chk($sformatf("v%0d_out_pc", i), 32'(out_pc), 32'(vec[i].opc));
            chk($sformatf("v%0d_out_inst", i), 32'(out_inst), 32'(16'hA000 + {12'h000, vec[i].opc}));
         end
      end

      // Reset mid-stream with stop and a branch present: reset wins.
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      reset = 1'b1; stop = 1'b1; out_ready = 1'b1;
      branch_valid = 1'b1; branch_target = 4'd9;
      #1;
      chk("rst2_mem_stop", 32'(mem_stop), 32'd1);
      edge_sample();
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      chk("rst2_out_pc", 32'(out_pc), 32'd0);
      chk("rst2_out_inst", 32'(out_inst), 32'd0);
      chk("rst2_pc", 32'(pc), 32'd0);

      reset = 1'b0; stop = 1'b0; branch_valid = 1'b0; branch_target = 4'd0;
      run_stream(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Fetch-side initiator for the 16x16 instruction memory. It drives the 4-bit PC, and it drives the memory's stop input so that a stall holds the memory's registered instruction output. It pairs each returned word with the PC that produced it and presents {instruction, pc} to the decoder through a valid/ready handshake. It also handles redirects (branches) from execute by discarding in-flight words.

Parameters:
PC_W, 4, PC / instruction-memory address width
INST_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset (top level drives the memory's active-low reset with ~reset)
stop  in  1  global halt; freezes all fetch state
pc  out  PC_W  address to instruction memory
mem_stop  out  1  to the memory's stop input; 1 = memory holds its output register
instruction  in  INST_W  registered memory output, equal to mem[pc] sampled one edge earlier while mem_stop=0
branch_valid  in  1  redirect request, single-cycle pulse
branch_target  in  PC_W  redirect address
out_valid  out  1  out_inst/out_pc hold a valid fetched word
out_ready  in  1  decoder accepts the word when out_valid&out_ready
out_inst  out  INST_W  fetched instruction
out_pc  out  PC_W  PC of out_inst

Behaviour:
- Internal registers:
  - pc_q, drives pc
  - req_valid and req_pc: tag for the word currently in the memory's output register
  - output register: out_valid, out_inst, out_pc
- adv = ~stop & (~out_valid | out_ready), combinational.
- mem_stop = ~adv, combinational. No skid buffer is needed, because a stalled memory holds its word.
- Reset, synchronous: pc_q=RESET_PC, req_valid=0, req_pc=0, out_valid=0, out_inst=0, out_pc=0. mem_stop follows adv, so it is 0 during reset with stop=0.
- On a clock edge with adv=1 and no branch:
  - pc_q <= pc_q+1, modulo 2^PC_W (15 -> 0, no flag).
  - req_valid <= 1, req_pc <= pc_q.
  - out_valid <= req_valid, out_inst <= instruction, out_pc <= req_pc.
- On an edge with adv=0 and no branch: every register holds. out_inst/out_pc are stable while out_valid&~out_ready.
- Branch has priority and is accepted on any edge where branch_valid=1, even when adv=0 or stop=1:
  - pc_q <= branch_target.
  - req_valid <= 0, discarding the word in flight.
  - out_valid <= 0, flushing the output, even if out_ready=1 that cycle.
  - Decoder must not count a handshake on a branch edge as a consumed word.
- Latency:
  - First valid word (pc=RESET_PC) is presented 2 adv edges after reset deasserts.
  - Branch sampled at edge E: out_valid with out_pc=target from edge E+2, given no stall.
  - Steady state: 1 word/cycle with out_ready=1.
- Stall during flush: with out_valid=0 only stop blocks adv, so the fetch pipeline refills while the decoder is idle.
- stop=1 mid-stream: nothing advances, and the memory holds via mem_stop. Release resumes exactly where it stopped, with no duplicate or lost word.
- reset asserted mid-stream: next edge clears to the reset state regardless of stop, branch or handshake.
- Ordering: words reach the decoder in PC order between branches. Every word with out_valid=1 satisfies out_inst == mem[out_pc].

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W, INST_W, RESET_PC
  - opcode field slice [15:12] and the register-field slices [11:8], [7:4], [3:0]
- No sub-module. The block is flat: PC register, tag register, output register and one adv equation.

Test Plan:
Unless stated otherwise, the bench memory model uses mem[k]=16'hA000+k with the memory's registered-output and stop-hold behaviour.
1. Reset, then out_ready=1 for 20 cycles -> out_pc sequence 0,1,...,15,0,1,2,3 with out_inst=16'hA000+out_pc; first out_valid 2 edges after reset deasserts.
2. out_ready=0 for 3 cycles while out_pc=5 -> out_valid=1, out_inst=16'hA005, mem_stop=1 held; on release next word is pc 6, no gap or duplicate.
3. branch_valid pulse with branch_target=12 while out_pc=3 is being accepted -> out_valid=0 for 2 cycles, then out_pc=12,13 with 16'hA00C, 16'hA00D; the in-flight pc 4 word is never presented.
4. stop=1 for 4 cycles mid-stream at out_pc=9, out_ready=1 -> pc, out_* and mem_stop=1 frozen; after release, sequence continues at 10.
5. branch_valid with branch_target=0 during out_ready=0 and out_valid=1 -> output flushed that edge; out_pc=0 appears 2 edges later.
6. reset asserted for 1 cycle while out_valid=1 and stop=1 -> all outputs cleared next edge; restart from pc 0 as in test 1.
